// File: rtl/titan_issue_pkg.sv
// Shared definitions for the titan issue scoreboard: register index width,
// per-register counter limit and the default-geometry EX slot record.
package titan_issue_pkg;

    localparam int NREGS_DEF     = 32;
    localparam int PAYLOAD_W_DEF = 128;

    // Index width for a register file of nregs entries (never below 1 bit).
    function automatic int reg_idx_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Largest value a cnt_w-bit outstanding-write counter may hold.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    localparam int REG_IDX_W = reg_idx_w(NREGS_DEF);

    // EX slot contents at the default geometry; the top re-declares the
    // same layout against its own parameters.
    typedef struct packed {
        logic [REG_IDX_W-1:0]     rd;
        logic                     we;
        logic [PAYLOAD_W_DEF-1:0] payload;
    } ex_slot_t;

endpackage

// File: rtl/titan_sb_counter.sv
// One register's outstanding-write counter. inc adds one, dec0 and dec1 each
// remove one, all in the same cycle; the result is clamped to [0, max].
// Removing more than is outstanding is a protocol error flagged in simulation.
module titan_sb_counter
    import titan_issue_pkg::*;
#(
    parameter int CNT_W = 2
)(
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc,
    input  logic dec0,
    input  logic dec1,
    output logic busy,
    output logic full,
    output logic last
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   up;
    logic [CNT_W:0]   dn;
    logic [CNT_W:0]   diff;

    // Net change of this cycle's events, clamped at both ends.
    always_comb begin
        up       = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
        dn       = {{CNT_W{1'b0}}, dec0} + {{CNT_W{1'b0}}, dec1};
        diff     = up - dn;
        cnt_next = cnt;
        if (up < dn) begin
            cnt_next = '0;
        end else if (diff > {1'b0, MAX_V}) begin
            cnt_next = MAX_V;
        end else begin
            cnt_next = diff[CNT_W-1:0];
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign busy = (cnt != '0);
    assign full = (cnt == MAX_V);
    assign last = (cnt == CNT_W'(1));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i) !(up < dn));

endmodule

// File: rtl/titan_issue_scoreboard.sv
// Issue stage between decode and EX. A per-register outstanding-write
// counter blocks issue on RAW/WAW hazards; one registered EX slot supports
// flush; hazard cycles are counted in a saturating perf counter.
// Optional build macro TITAN_WB_BYPASS_EN: a source whose last outstanding
// write is retiring this cycle is not treated as a hazard.
//
// Handshakes: id side transfers when id_valid_i && id_ready_o at a rising
// edge; id_ready_o never depends on id_valid_i. EX side consumes the slot
// when ex_valid_o && ex_ready_i at a rising edge; the slot holds otherwise.
module titan_issue_scoreboard
    import titan_issue_pkg::*;
#(
    parameter  int NREGS     = NREGS_DEF,
    parameter  int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter  int CNT_W     = 2,
    parameter  int PERF_W    = 32,
    localparam int IDX_W     = reg_idx_w(NREGS)
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 id_valid_i,
    output logic                 id_ready_o,
    input  logic [IDX_W-1:0]     id_rs1_i,
    input  logic [IDX_W-1:0]     id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic [IDX_W-1:0]     id_rd_i,
    input  logic                 id_we_i,
    input  logic [PAYLOAD_W-1:0] id_payload_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [IDX_W-1:0]     ex_rd_o,
    output logic                 ex_we_o,
    output logic [PAYLOAD_W-1:0] ex_payload_o,
    input  logic                 flush_i,
    input  logic                 wb_valid_i,
    input  logic [IDX_W-1:0]     wb_rd_i,
    output logic                 hazard_o,
    output logic [PERF_W-1:0]    stall_cnt_o
);

`ifdef TITAN_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [IDX_W-1:0]     rd;
        logic                 we;
        logic [PAYLOAD_W-1:0] payload;
    } slot_t;

    slot_t             slot_q;
    logic              slot_valid_q;
    logic [PERF_W-1:0] stall_q;

    // Entry 0 stays zero: x0 is never busy, never full.
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] full;
    logic [NREGS-1:0] last;

    logic rs1_block;
    logic rs2_block;
    logic raw;
    logic waw;
    logic slot_free;
    logic fire;

    assign busy[0] = 1'b0;
    assign full[0] = 1'b0;
    assign last[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        logic inc;
        logic dec_wb;
        logic dec_fl;
        assign inc    = fire && id_we_i && (id_rd_i == IDX_W'(r));
        assign dec_wb = wb_valid_i && (wb_rd_i == IDX_W'(r));
        // A killed slot never reaches writeback, so its claim is returned.
        assign dec_fl = flush_i && slot_valid_q && slot_q.we && (slot_q.rd == IDX_W'(r));
        titan_sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (inc),
            .dec0  (dec_wb),
            .dec1  (dec_fl),
            .busy  (busy[r]),
            .full  (full[r]),
            .last  (last[r])
        );
    end

    // Hazard detection and the id-side ready.
    always_comb begin
        rs1_block  = busy[id_rs1_i] &&
                     !(BYPASS && wb_valid_i && (wb_rd_i == id_rs1_i) && last[id_rs1_i]);
        rs2_block  = busy[id_rs2_i] &&
                     !(BYPASS && wb_valid_i && (wb_rd_i == id_rs2_i) && last[id_rs2_i]);
        raw        = (id_use_rs1_i && rs1_block) || (id_use_rs2_i && rs2_block);
        waw        = id_we_i && full[id_rd_i];
        slot_free  = !slot_valid_q || ex_ready_i;
        id_ready_o = slot_free && !(raw || waw) && !flush_i;
        hazard_o   = id_valid_i && (raw || waw);
        fire       = id_valid_i && id_ready_o;
    end

    // EX slot: flush kills, issue captures, consumption empties, else hold.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
        end else if (flush_i) begin
            slot_valid_q <= 1'b0;
        end else if (fire) begin
            slot_valid_q <= 1'b1;
            slot_q       <= '{rd: id_rd_i, we: id_we_i, payload: id_payload_i};
        end else if (ex_ready_i) begin
            slot_valid_q <= 1'b0;
        end
    end

    // Saturating count of cycles held by a hazard.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_q <= '0;
        end else if (hazard_o && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign ex_valid_o   = slot_valid_q;
    assign ex_rd_o      = slot_q.rd;
    assign ex_we_o      = slot_q.we;
    assign ex_payload_o = slot_q.payload;
    assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_titan_issue_scoreboard.sv
// Self-checking bench for titan_issue_scoreboard. Issued instructions are
// pushed to an expected queue and compared against the EX slot one cycle
// after each handshake; scenario tasks check ready/hazard/stall inline.
module tb_titan_issue_scoreboard;

    localparam int NREGS     = 32;
    localparam int PAYLOAD_W = 128;
    localparam int CNT_W     = 2;
    localparam int PERF_W    = 4;
    localparam int IDX_W     = 5;
    localparam int EXP_W     = IDX_W + 1 + PAYLOAD_W;
    localparam logic [PERF_W-1:0] PMAX = '1;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 id_valid_i = 1'b0;
    logic                 id_ready_o;
    logic [IDX_W-1:0]     id_rs1_i = '0;
    logic [IDX_W-1:0]     id_rs2_i = '0;
    logic                 id_use_rs1_i = 1'b0;
    logic                 id_use_rs2_i = 1'b0;
    logic [IDX_W-1:0]     id_rd_i = '0;
    logic                 id_we_i = 1'b0;
    logic [PAYLOAD_W-1:0] id_payload_i = '0;
    logic                 ex_valid_o;
    logic                 ex_ready_i = 1'b1;
    logic [IDX_W-1:0]     ex_rd_o;
    logic                 ex_we_o;
    logic [PAYLOAD_W-1:0] ex_payload_o;
    logic                 flush_i = 1'b0;
    logic                 wb_valid_i = 1'b0;
    logic [IDX_W-1:0]     wb_rd_i = '0;
    logic                 hazard_o;
    logic [PERF_W-1:0]    stall_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    logic [EXP_W-1:0]     exp_q[$];
    logic [EXP_W-1:0]     mon_exp;
    logic [EXP_W-1:0]     mon_got;
    logic                 fire_seen = 1'b0;
    logic [PERF_W-1:0]    exp_stall = '0;
    logic [PAYLOAD_W-1:0] cur_pl;
    logic [PAYLOAD_W-1:0] held_pl;

    titan_issue_scoreboard #(
        .NREGS(NREGS), .PAYLOAD_W(PAYLOAD_W), .CNT_W(CNT_W), .PERF_W(PERF_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_payload_i(id_payload_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rd_o(ex_rd_o), .ex_we_o(ex_we_o), .ex_payload_o(ex_payload_o),
        .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .hazard_o(hazard_o), .stall_cnt_o(stall_cnt_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) fire_seen = rst_i && id_valid_i && id_ready_o;

    always @(posedge clk) begin
        if (fire_seen) begin
            #1;
            n_total++;
            mon_got = {ex_rd_o, ex_we_o, ex_payload_o};
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: issued slot=%h with nothing expected", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (!ex_valid_o || mon_got !== mon_exp) begin
                    n_bad++;
                    $display("FAIL sb_slot: valid=%0b got=%h want=%h", ex_valid_o, mon_got, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid_i = 1'b0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_we_i = 1'b0;
        ex_ready_i = 1'b1; flush_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0;
    endtask

    task automatic drive_id(input logic [IDX_W-1:0] rs1, input logic u1,
                            input logic [IDX_W-1:0] rs2, input logic u2,
                            input logic [IDX_W-1:0] rd, input logic we);
        cur_pl = {$urandom(), $urandom(), $urandom(), $urandom()};
        id_valid_i = 1'b1;
        id_rs1_i = rs1; id_use_rs1_i = u1;
        id_rs2_i = rs2; id_use_rs2_i = u2;
        id_rd_i = rd; id_we_i = we; id_payload_i = cur_pl;
    endtask

    task automatic push_exp();
        exp_q.push_back({id_rd_i, id_we_i, id_payload_i});
    endtask

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == PMAX) ? v : v + 1'b1;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle(); rst_i = 1'b0;
        step(); step();
        n_total++; if (ex_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid: got=%0b want=0", ex_valid_o); end
        n_total++; if (ex_rd_o !== '0) begin n_bad++; $display("FAIL reset_ex_rd: got=%0d want=0", ex_rd_o); end
        n_total++; if (ex_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_ex_we: got=%0b want=0", ex_we_o); end
        n_total++; if (ex_payload_o !== '0) begin n_bad++; $display("FAIL reset_ex_payload: got=%h want=0", ex_payload_o); end
        n_total++; if (stall_cnt_o !== '0) begin n_bad++; $display("FAIL reset_stall: got=%0d want=0", stall_cnt_o); end
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL reset_hazard: got=%0b want=0", hazard_o); end
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got=%0b want=1", id_ready_o); end
        rst_i = 1'b1; exp_stall = '0;
        step();
    endtask

    task automatic test_issue_raw();
        idle(); step();
        drive_id(0, 0, 0, 0, 5, 1); #1;
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL raw_first_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step();
        n_total++; if (ex_rd_o !== 5'd5) begin n_bad++; $display("FAIL raw_ex_rd: got=%0d want=5", ex_rd_o); end
        drive_id(5, 1, 0, 0, 6, 0); #1;
        n_total++; if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL raw_hazard: got=%0b want=1", hazard_o); end
        n_total++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL raw_ready: got=%0b want=0", id_ready_o); end
        for (int i = 0; i < 2; i++) begin
            step(); exp_stall = sat_inc(exp_stall);
            n_total++; if (stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL raw_stall_cnt: got=%0d want=%0d", stall_cnt_o, exp_stall); end
        end
        wb_valid_i = 1'b1; wb_rd_i = 5; #1;
`ifdef TITAN_WB_BYPASS_EN
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step(); wb_valid_i = 1'b0;
`else
        n_total++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL raw_wb_cycle_ready: got=%0b want=0", id_ready_o); end
        step(); exp_stall = sat_inc(exp_stall); wb_valid_i = 1'b0; #1;
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL raw_after_wb_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step();
`endif
        n_total++; if (stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL raw_stall_final: got=%0d want=%0d", stall_cnt_o, exp_stall); end
        idle();
    endtask

    task automatic test_waw_back_to_back();
        idle(); step();
        for (int i = 0; i < 3; i++) begin
            drive_id(0, 0, 0, 0, 3, 1); #1;
            n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL waw_fill_ready[%0d]: got=%0b want=1", i, id_ready_o); end
            push_exp(); step();
        end
        drive_id(0, 0, 0, 0, 3, 1); #1;
        n_total++; if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL waw_hazard: got=%0b want=1", hazard_o); end
        n_total++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL waw_ready: got=%0b want=0", id_ready_o); end
        step(); exp_stall = sat_inc(exp_stall);
        wb_valid_i = 1'b1; wb_rd_i = 3; #1;
        n_total++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL waw_wb_cycle_ready: got=%0b want=0", id_ready_o); end
        step(); exp_stall = sat_inc(exp_stall); wb_valid_i = 1'b0; #1;
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL waw_after_wb_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step();
        n_total++; if (stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL waw_stall_cnt: got=%0d want=%0d", stall_cnt_o, exp_stall); end
        idle(); wb_valid_i = 1'b1; wb_rd_i = 3;
        step(); step(); step();
        wb_valid_i = 1'b0;
        drive_id(3, 1, 0, 0, 4, 0); #1;
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL waw_drained_hazard: got=%0b want=0", hazard_o); end
        push_exp(); step(); idle();
    endtask

    task automatic test_backpressure();
        idle(); step();
        ex_ready_i = 1'b0;
        drive_id(0, 0, 0, 0, 10, 0); #1;
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_first_ready: got=%0b want=1", id_ready_o); end
        push_exp(); held_pl = cur_pl; step();
        drive_id(0, 0, 0, 0, 11, 0); #1;
        n_total++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got=%0b want=0", id_ready_o); end
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL bp_hazard: got=%0b want=0", hazard_o); end
        step();
        n_total++; if (ex_valid_o !== 1'b1 || ex_payload_o !== held_pl) begin n_bad++; $display("FAIL bp_hold: valid=%0b got=%h want=%h", ex_valid_o, ex_payload_o, held_pl); end
        n_total++; if (stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL bp_stall_cnt: got=%0d want=%0d", stall_cnt_o, exp_stall); end
        ex_ready_i = 1'b1; #1;
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step(); idle();
    endtask

    task automatic test_flush();
        idle(); step();
        ex_ready_i = 1'b0;
        drive_id(0, 0, 0, 0, 7, 1); #1;
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_first_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step();
        flush_i = 1'b1; ex_ready_i = 1'b1;
        drive_id(0, 0, 0, 0, 8, 1); #1;
        n_total++; if (id_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got=%0b want=0", id_ready_o); end
        step(); flush_i = 1'b0; id_valid_i = 1'b0; #1;
        n_total++; if (ex_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_ex_valid: got=%0b want=0", ex_valid_o); end
        drive_id(7, 1, 0, 0, 8, 0); #1;
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL flush_cnt_returned: hazard got=%0b want=0", hazard_o); end
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_after_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step(); idle();
    endtask

    task automatic test_x0();
        idle(); step();
        for (int i = 0; i < 4; i++) begin
            drive_id(0, 0, 0, 0, 0, 1); #1;
            n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL x0_write_ready[%0d]: got=%0b want=1", i, id_ready_o); end
            push_exp(); step();
        end
        drive_id(0, 1, 0, 1, 0, 1); #1;
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL x0_read_hazard: got=%0b want=0", hazard_o); end
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL x0_read_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step(); idle();
    endtask

    task automatic test_issue_wb_same();
        idle(); step();
        drive_id(0, 0, 0, 0, 9, 1); #1; push_exp(); step();
        drive_id(0, 0, 0, 0, 9, 1); wb_valid_i = 1'b1; wb_rd_i = 9; #1;
        n_total++; if (id_ready_o !== 1'b1) begin n_bad++; $display("FAIL same_issue_wb_ready: got=%0b want=1", id_ready_o); end
        push_exp(); step();
        wb_valid_i = 1'b0;
        drive_id(9, 1, 0, 0, 0, 0); #1;
        n_total++; if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL same_cnt_nonzero: hazard got=%0b want=1", hazard_o); end
        wb_valid_i = 1'b1; wb_rd_i = 9; #1;
`ifdef TITAN_WB_BYPASS_EN
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL same_cnt_one_bypass: hazard got=%0b want=0", hazard_o); end
        push_exp(); step();
`else
        step(); exp_stall = sat_inc(exp_stall); wb_valid_i = 1'b0; #1;
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL same_cnt_one: hazard got=%0b want=0", hazard_o); end
        push_exp(); step();
`endif
        idle(); step();
        n_total++; if (stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL same_stall_cnt: got=%0d want=%0d", stall_cnt_o, exp_stall); end
    endtask

    task automatic test_reset_mid_stall();
        idle(); step();
        ex_ready_i = 1'b0;
        drive_id(0, 0, 0, 0, 12, 1); #1; push_exp(); step();
        drive_id(12, 1, 0, 0, 0, 0); #1;
        n_total++; if (hazard_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_hazard: got=%0b want=1", hazard_o); end
        step(); exp_stall = sat_inc(exp_stall);
        rst_i = 1'b0; step();
        n_total++; if (ex_valid_o !== 1'b0 || ex_rd_o !== '0 || ex_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_slot: valid=%0b rd=%0d we=%0b want 0/0/0", ex_valid_o, ex_rd_o, ex_we_o); end
        n_total++; if (ex_payload_o !== '0) begin n_bad++; $display("FAIL rst_mid_payload: got=%h want=0", ex_payload_o); end
        n_total++; if (stall_cnt_o !== '0) begin n_bad++; $display("FAIL rst_mid_stall: got=%0d want=0", stall_cnt_o); end
        n_total++; if (hazard_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_cnt_cleared: hazard got=%0b want=0", hazard_o); end
        idle(); rst_i = 1'b1; exp_stall = '0; step();
    endtask

    task automatic test_stall_saturate();
        idle(); step();
        drive_id(0, 0, 0, 0, 14, 1); #1; push_exp(); step();
        drive_id(14, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(); exp_stall = sat_inc(exp_stall);
        end
        n_total++; if (stall_cnt_o !== exp_stall) begin n_bad++; $display("FAIL stall_saturate: got=%0d want=%0d", stall_cnt_o, exp_stall); end
        idle(); wb_valid_i = 1'b1; wb_rd_i = 14; step();
        idle(); step();
        n_total++; if (stall_cnt_o !== PMAX) begin n_bad++; $display("FAIL stall_hold_max: got=%0d want=%0d", stall_cnt_o, PMAX); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_issue_raw();
        test_waw_back_to_back();
        test_backpressure();
        test_flush();
        test_x0();
        test_issue_wb_same();
        test_reset_mid_stall();
        test_stall_saturate();
        step(); step();
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
